vga_rx: RTL
===========

# vga_rx

Receive-side VGA timing decoder for the pong display path. It samples a 640x480@60 VGA signal (hs, vs, 12-bit RGB) as produced by the game's video generator and recovers pixel coordinates and a valid strobe. It checks line and frame timing against parameterised limits and reports errors. It is used as an on-chip loopback monitor and as the bench-side checker for the generator.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_SYNC, 96, hs low width (cycles)
- H_BACK, 48, back porch after hs rise
- H_TOTAL, 800, cycles per line
- V_VISIBLE, 480, visible lines per frame
- V_SYNC, 2, vs low width (lines)
- V_BACK, 33, back porch lines after vs
- V_TOTAL, 525, lines per frame
- clk  in  1  pixel clock; only clock
- rst  in  1  synchronous, active-high reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- rgb  in  12  {r[3:0],g[3:0],b[3:0]}
- px_valid  out  1  visible pixel on px_* this cycle
- px_x  out  10  column 0..H_VISIBLE-1
- px_y  out  10  row 0..V_VISIBLE-1
- px_rgb  out  12  captured pixel
- line_start  out  1  pulse with px_x==0 and px_valid
- frame_start  out  1  pulse with px_x==0, px_y==0, px_valid
- locked  out  1  timing verified
- err  out  1  one-cycle pulse per timing violation
- err_count  out  8  saturating violation count
- frame_crc  out  16  CRC of last complete visible frame
- crc_valid  out  1  pulse when frame_crc updates

## Operation
- Input stage: hs, vs and rgb are registered once. All detection runs on the registered copies.
- hcount (10b): set to 0 on the hs falling edge; otherwise increments.
- vs falling edge sets vs_pend. The next hs falling edge sets vcount=0 and clears vs_pend; every other hs falling edge increments vcount.
- If hs and vs fall in the same cycle, vs_pend is consumed by that same edge.
- Visible window:
  - columns: hcount in [H_SYNC+H_BACK, +H_VISIBLE), i.e. 144..783
  - rows: vcount in [V_SYNC+V_BACK, +V_VISIBLE), i.e. 35..514
  - px_x = hcount-144, px_y = vcount-35
- Checks; each raises err and sends the FSM to SEARCH:
  - hs fall with hcount != H_TOTAL-1
  - hcount reaching H_TOTAL with no hs fall
  - hs rise with hcount != H_SYNC
  - frame boundary (vcount reset) with vcount != V_TOTAL-1
  - vcount reaching V_TOTAL with no boundary
- Checks apply only once the preceding edge is known: no period check on the first hs fall, no frame check on the first boundary.
- FSM:
  - SEARCH → HTRACK on the first hs fall.
  - HTRACK → VTRACK on the first frame boundary.
  - VTRACK → LOCKED on the next boundary that passes the frame check.
  - Any error in any state → SEARCH.
- locked is high only in LOCKED. px_valid, line_start and frame_start are gated by locked.
- err_count saturates at 255 and clears only on rst.

## Timing
- Latency: input sampled at cycle t appears on px_* at t+2. err is flagged at t+2 relative to the offending input edge.
- locked rises 2 cycles after the sampled hs fall that completes the second verified frame boundary. locked falls the cycle after err.
- Reset values: all outputs 0; FSM in SEARCH; hcount, vcount and vs_pend cleared.
- Reset mid-frame: decoding restarts from SEARCH. A full relock is required (two frame boundaries).
- px_x and px_y hold their last value when px_valid is 0.

## Configuration
- VGA_RX_CRC_EN defined:
  - Uses CRC-16-CCITT, poly 0x1021, init 0xFFFF, non-reflected.
  - Each px_valid cycle updates the CRC with the 12 rgb bits, MSB first.
  - CRC is reinitialised on frame_start.
  - After the pixel px_x=639, px_y=479, frame_crc latches and crc_valid pulses one cycle later.
- VGA_RX_CRC_EN undefined: frame_crc=0, crc_valid=0, no CRC logic.

## Test plan
- Nominal 800x525 timing, 3 frames, rst released at frame start → locked high during frame 3; exactly 307200 px_valid per locked frame; first px_x/px_y = 0/0 with frame_start; err_count=0.
- One line of 799 cycles while locked → single err pulse; err_count=1; locked low next cycle; relocks after two good boundaries.
- hs low width 95 → err at the hs rise; FSM returns to SEARCH.
- hs and vs fall in the same cycle → vcount=0 on that edge; lock achieved normally with no err.
- rst asserted mid-line while locked → all outputs 0 next cycle; relock takes two frame boundaries.
- CRC_EN: two identical frames → equal frame_crc matching a golden model. Flip one pixel bit in the next frame → frame_crc differs. crc_valid pulses once per frame.

Source files
------------

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receive timing decoder with lock FSM; frame CRC enabled by VGA_RX_CRC_EN
module vga_rx #(
  parameter int H_VISIBLE = 640,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_TOTAL   = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [11:0] rgb,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [11:0] px_rgb,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic [9:0] HX0    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HX1    = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] VY0    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VY1    = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_END  = 10'(H_TOTAL);
  localparam logic [9:0] HS_W   = 10'(H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_END  = 10'(V_TOTAL);
  localparam logic [9:0] X_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_VISIBLE - 1);

  typedef enum logic [1:0] {SEARCH, HTRACK, VTRACK, LOCKED} state_t;

  state_t      state, state_n;
  logic        hs_q, vs_q, hs_d, vs_d;
  logic [11:0] rgb_q;
  logic [9:0]  h_prev, v_prev;
  logic        vs_pend;

  logic        hs_fall, hs_rise, vs_fall, boundary;
  logic [9:0]  cur_h, cur_v;
  logic        h_chk, v_chk, err_n, vis, show;

  // h_prev/v_prev hold the count of the previous registered sample; cur_* is this sample's count
  always_comb begin
    hs_fall  = hs_d & ~hs_q;
    hs_rise  = ~hs_d & hs_q;
    vs_fall  = vs_d & ~vs_q;
    boundary = hs_fall & (vs_pend | vs_fall);
    cur_h    = hs_fall ? 10'd0 : h_prev + 10'd1;
    if (boundary)
      cur_v = 10'd0;
    else if (hs_fall)
      cur_v = v_prev + 10'd1;
    else
      cur_v = v_prev;

    h_chk = (state != SEARCH);
    v_chk = (state == VTRACK) || (state == LOCKED);
    err_n = (h_chk && ((hs_fall && h_prev != H_LAST) ||
                       (!hs_fall && cur_h == H_END) ||
                       (hs_rise && cur_h != HS_W))) ||
            (v_chk && ((boundary && v_prev != V_LAST) ||
                       (hs_fall && !boundary && cur_v == V_END)));

    vis = (cur_h >= HX0) && (cur_h < HX1) && (cur_v >= VY0) && (cur_v < VY1);
  end

  // The registered err drives the FSM, so locked drops the cycle after the err pulse
  always_comb begin
    state_n = state;
    if (err) begin
      state_n = SEARCH;
    end else begin
      case (state)
        SEARCH:  if (hs_fall) state_n = HTRACK;
        HTRACK:  if (boundary) state_n = VTRACK;
        VTRACK:  if (boundary && !err_n) state_n = LOCKED;
        LOCKED:  state_n = LOCKED;
        default: state_n = SEARCH;
      endcase
    end
    show = vis && (state_n == LOCKED);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      rgb_q       <= '0;
      h_prev      <= '0;
      v_prev      <= '0;
      vs_pend     <= 1'b0;
      state       <= SEARCH;
      err         <= 1'b0;
      err_count   <= '0;
      px_valid    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      rgb_q   <= rgb;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      h_prev  <= cur_h;
      v_prev  <= cur_v;
      if (boundary)
        vs_pend <= 1'b0;
      else if (vs_fall)
        vs_pend <= 1'b1;
      state <= state_n;
      err   <= err_n;
      if (err_n && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      px_valid    <= show;
      line_start  <= show && (cur_h == HX0);
      frame_start <= show && (cur_h == HX0) && (cur_v == VY0);
      if (show) begin
        px_x   <= cur_h - HX0;
        px_y   <= cur_v - VY0;
        px_rgb <= rgb_q;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc, crc_n;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i])
        r = {r[14:0], 1'b0} ^ 16'h1021;
      else
        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_n = crc_step(frame_start ? 16'hFFFF : crc, px_rgb);
  end

  // The last visible pixel's update is latched straight into frame_crc
  always_ff @(posedge clk) begin
    if (rst) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (px_valid) begin
        crc <= crc_n;
        if (px_x == X_LAST && px_y == Y_LAST) begin
          frame_crc <= crc_n;
          crc_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif

endmodule
